// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
// Management-side transmitter for the GPIO configuration shift chain. Holds one
// PAD_CTRL_BITS word per GPIO and, on start, shifts every word into the daisy-chained
// control blocks (farthest word first, MSB first), then issues a two-cycle load strobe.
//
// Ports:
//   serial_clock  block clock, all state changes on its rising edge
//   resetn        asynchronous active-low reset
//   cfg_we        configuration write strobe (ignored while a transfer is in progress)
//   cfg_addr      GPIO index for write and readback
//   cfg_wdata     configuration word to write
//   cfg_rdata     combinational readback of the word at cfg_addr (0 if out of range)
//   start         single-cycle transfer request
//   busy          high from the cycle after an accepted start until done
//   done          one-cycle pulse after the load strobe
//   chain_clock   serial clock into the chain
//   chain_data    serial data into the first block
//   chain_load    load strobe into the chain
//   chain_resetn  resetn passed straight through
`timescale 1ns/1ps

module gpio_serial_loader #(
  parameter int unsigned              NUM_GPIO      = 38,
  parameter int unsigned              PAD_CTRL_BITS = 13,
  parameter logic [PAD_CTRL_BITS-1:0] CFG_RESET     = 13'h0403
) (
  input  logic                        serial_clock,
  input  logic                        resetn,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_GPIO)-1:0] cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]    cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0]    cfg_rdata,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        chain_clock,
  output logic                        chain_data,
  output logic                        chain_load,
  output logic                        chain_resetn
);

  localparam int unsigned AddrW = $clog2(NUM_GPIO);
  localparam int unsigned BitW  = $clog2(PAD_CTRL_BITS);

  localparam logic [AddrW-1:0] LastGpio = AddrW'(NUM_GPIO - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(PAD_CTRL_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLoadSetup,
    StLoad,
    StFinish
  } state_e;

  state_e                   state_q, state_d;
  logic [AddrW-1:0]         gpio_q, gpio_d;
  logic [BitW-1:0]          bit_q, bit_d;
  logic                     load_cnt_q, load_cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     clk_q, clk_d;
  logic                     data_q, data_d;
  logic                     load_q, load_d;
  logic [PAD_CTRL_BITS-1:0] mem_q [NUM_GPIO];

  logic addr_ok;
  logic wr_en;
  logic cur_bit;

  assign addr_ok = (cfg_addr <= LastGpio);

  // Writes are only taken while the FSM is idle, so the array is stable for the
  // whole transfer without needing a snapshot copy.
  assign wr_en   = cfg_we && addr_ok && (state_q == StIdle);

  assign cur_bit = mem_q[gpio_q][bit_q];

  assign cfg_rdata = addr_ok ? mem_q[cfg_addr] : '0;

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_GPIO; i++) begin
        mem_q[i] <= CFG_RESET;
      end
    end else if (wr_en) begin
      mem_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Outputs are registered from the current state, so they trail the state register by
  // one cycle: start at edge t gives SHIFT_LO outputs at t+1 and the first rise at t+2.
  always_comb begin
    state_d    = state_q;
    gpio_d     = gpio_q;
    bit_d      = bit_q;
    load_cnt_d = load_cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    clk_d      = 1'b0;
    data_d     = 1'b0;
    load_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShiftLo;
          gpio_d  = LastGpio;
          bit_d   = LastBit;
        end
      end
      StShiftLo: begin
        busy_d  = 1'b1;
        data_d  = cur_bit;
        state_d = StShiftHi;
      end
      StShiftHi: begin
        busy_d = 1'b1;
        clk_d  = 1'b1;
        data_d = data_q;
        if (bit_q != '0) begin
          bit_d   = bit_q - BitW'(1);
          state_d = StShiftLo;
        end else if (gpio_q != '0) begin
          gpio_d  = gpio_q - AddrW'(1);
          bit_d   = LastBit;
          state_d = StShiftLo;
        end else begin
          state_d = StLoadSetup;
        end
      end
      StLoadSetup: begin
        busy_d     = 1'b1;
        load_cnt_d = 1'b0;
        state_d    = StLoad;
      end
      StLoad: begin
        busy_d = 1'b1;
        load_d = 1'b1;
        if (load_cnt_q) begin
          state_d = StFinish;
        end else begin
          load_cnt_d = 1'b1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      gpio_q     <= '0;
      bit_q      <= '0;
      load_cnt_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clk_q      <= 1'b0;
      data_q     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gpio_q     <= gpio_d;
      bit_q      <= bit_d;
      load_cnt_q <= load_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clk_q      <= clk_d;
      data_q     <= data_d;
      load_q     <= load_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign chain_clock  = clk_q;
  assign chain_data   = data_q;
  assign chain_load   = load_q;
  assign chain_resetn = resetn;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader: randomized configuration traffic, a
// cycle-timeline reference for the serial protocol, and a model of the 38 chained
// control blocks that latches on the load strobe.
`timescale 1ns/1ps

module tb_gpio_serial_loader;

  localparam int N    = 38;
  localparam int W    = 13;
  localparam int NW   = N * W;
  localparam int XFER = 2 * NW + 4;

  logic        serial_clock = 1'b0;
  logic        resetn       = 1'b0;
  logic        cfg_we       = 1'b0;
  logic [5:0]  cfg_addr     = '0;
  logic [12:0] cfg_wdata    = '0;
  logic [12:0] cfg_rdata;
  logic        start        = 1'b0;
  logic        busy;
  logic        done;
  logic        chain_clock;
  logic        chain_data;
  logic        chain_load;
  logic        chain_resetn;

  gpio_serial_loader dut (
    .serial_clock (serial_clock),
    .resetn       (resetn),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .chain_clock  (chain_clock),
    .chain_data   (chain_data),
    .chain_load   (chain_load),
    .chain_resetn (chain_resetn)
  );

  initial forever #5 serial_clock = ~serial_clock;

  int vectors = 0;
  int errors  = 0;

  // Reference state
  logic [12:0] ref_mem [N];
  int          cyc     = 0;
  bit          active  = 1'b0;
  int          t_start = 0;

  // Chain-block model and event counters
  logic [NW-1:0] sr;
  logic [12:0]   latched [N];
  int            rises       = 0;
  int            load_cycles = 0;
  int            done_cnt    = 0;
  int            done_cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic stream_bit(input int k);
    int g;
    int b;
    g = N - 1 - k / W;
    b = W - 1 - k % W;
    return ref_mem[g][b];
  endfunction

  // Reference model: array contents and transfer start edge. A new start or write is only
  // honoured once the previous transfer has fully returned to idle (edge t+XFER+1).
  initial forever begin
    @(posedge serial_clock or negedge resetn);
    if (!resetn) begin
      for (int i = 0; i < N; i++) ref_mem[i] = 13'h0403;
      active = 1'b0;
    end else begin
      bit idle;
      cyc++;
      idle = !active || ((cyc - t_start) >= XFER + 1);
      if (idle && cfg_we && (cfg_addr < N)) ref_mem[cfg_addr] = cfg_wdata;
      if (idle && start) begin
        active  = 1'b1;
        t_start = cyc;
      end
    end
  end

  // Compare process: sampled mid-cycle on the falling edge.
  initial begin
    logic prev_clk;
    logic prev_data;
    logic prev_load;
    int   d;
    logic e_busy, e_clk, e_data, e_load, e_done;
    prev_clk  = 1'b0;
    prev_data = 1'b0;
    prev_load = 1'b0;
    forever begin
      @(negedge serial_clock);
      check("chain_resetn", 32'(chain_resetn), 32'(resetn));
      if (!chain_resetn) begin
        prev_clk  = 1'b0;
        prev_data = 1'b0;
        prev_load = 1'b0;
        sr        = '0;
        for (int i = 0; i < N; i++) latched[i] = '0;
      end else begin
        d      = cyc - t_start;
        e_busy = active && (d >= 1) && (d <= XFER - 1);
        e_clk  = active && (d >= 2) && (d <= 2 * NW) && (d % 2 == 0);
        e_data = (active && (d >= 1) && (d <= 2 * NW)) ? stream_bit((d - 1) / 2) : 1'b0;
        e_load = active && ((d == 2 * NW + 2) || (d == 2 * NW + 3));
        e_done = active && (d == XFER);
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("chain_clock", 32'(chain_clock), 32'(e_clk));
        check("chain_data", 32'(chain_data), 32'(e_data));
        check("chain_load", 32'(chain_load), 32'(e_load));
        check("cfg_rdata", 32'(cfg_rdata), (cfg_addr < N) ? 32'(ref_mem[cfg_addr]) : 32'd0);
        check("load_while_clk_hi", 32'(chain_load & chain_clock), 32'd0);
        if (chain_clock) check("data_stable_clk_hi", 32'(chain_data), 32'(prev_data));
        if (chain_clock && !prev_clk) begin
          rises++;
          sr = {sr[NW-2:0], chain_data};
        end
        if (chain_load) load_cycles++;
        if (chain_load && !prev_load) begin
          for (int i = 0; i < N; i++) latched[i] = sr[i*W +: W];
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_clk  = chain_clock;
        prev_data = chain_data;
        prev_load = chain_load;
      end
    end
  end

  task automatic tick();
    @(posedge serial_clock);
    #2;
  endtask

  task automatic write(input int a, input logic [12:0] v);
    cfg_we    = 1'b1;
    cfg_addr  = a[5:0];
    cfg_wdata = v;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic read_check(input string name, input int a, input logic [12:0] exp);
    cfg_addr = a[5:0];
    #1;
    check(name, 32'(cfg_rdata), 32'(exp));
  endtask

  task automatic clear_counts();
    rises       = 0;
    load_cycles = 0;
    done_cnt    = 0;
    done_cyc    = 0;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    tick();
    start = 1'b0;
    t     = t_start;
  endtask

  // Waits (bounded) for done, then checks the transfer-level numbers.
  task automatic finish_xfer(input int t);
    for (int i = 0; i < XFER + 50 && done_cnt == 0; i++) tick();
    check("done_seen", 32'(done_cnt), 32'd1);
    check("start_to_done", 32'(done_cyc - t), 32'd992);
    repeat (3) tick();
    check("done_once", 32'(done_cnt), 32'd1);
    check("chain_rises", 32'(rises), 32'd494);
    check("load_cycles", 32'(load_cycles), 32'd2);
  endtask

  task automatic check_latched_vs_model();
    for (int i = 0; i < N; i++) check("block_latch", 32'(latched[i]), 32'(ref_mem[i]));
  endtask

  initial begin
    int          t;
    logic [12:0] old0;

    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_chain_clock", 32'(chain_clock), 32'd0);
    check("rst_chain_data", 32'(chain_data), 32'd0);
    check("rst_chain_load", 32'(chain_load), 32'd0);
    for (int i = 0; i < N; i++) read_check("rst_rdata", i, 13'h0403);

    // Write / readback including an out-of-range address
    write(5, 13'h1ABC);
    write(37, 13'h0001);
    write(40, 13'h0000);
    read_check("rd_addr5", 5, 13'h1ABC);
    read_check("rd_addr37", 37, 13'h0001);
    read_check("rd_addr40", 40, 13'h0000);
    read_check("rd_addr4", 4, 13'h0403);
    read_check("rd_addr6", 6, 13'h0403);
    read_check("rd_addr36", 36, 13'h0403);
    read_check("rd_addr0", 0, 13'h0403);

    // Full transfer of random words
    for (int i = 0; i < N; i++) write(i, 13'($urandom));
    clear_counts();
    pulse_start(t);
    finish_xfer(t);
    check_latched_vs_model();

    // start and write while busy are both ignored
    for (int i = 0; i < N; i++) write(i, 13'($urandom));
    old0 = ref_mem[0];
    clear_counts();
    pulse_start(t);
    for (int i = 0; i < 200 && cyc < t + 99; i++) tick();
    start     = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 6'd0;
    cfg_wdata = ~old0;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    finish_xfer(t);
    read_check("busy_write_dropped", 0, old0);
    check_latched_vs_model();

    // Reset in the middle of a transfer
    clear_counts();
    pulse_start(t);
    for (int i = 0; i < 400 && cyc < t + 300; i++) tick();
    resetn = 1'b0;
    #1;
    check("midrst_chain_clock", 32'(chain_clock), 32'd0);
    check("midrst_chain_load", 32'(chain_load), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_chain_data", 32'(chain_data), 32'd0);
    check("midrst_chain_resetn", 32'(chain_resetn), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_no_load", 32'(load_cycles), 32'd0);
    for (int i = 0; i < N; i++) read_check("midrst_rdata", i, 13'h0403);
    clear_counts();
    pulse_start(t);
    finish_xfer(t);
    for (int i = 0; i < N; i++) check("post_rst_latch", 32'(latched[i]), 32'h0403);

    // Random configuration traffic, with a write landing in the same cycle as start
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) begin
        cfg_we    = 1'($urandom);
        cfg_addr  = 6'($urandom_range(0, 63));
        cfg_wdata = 13'($urandom);
        tick();
      end
      clear_counts();
      cfg_we    = 1'b1;
      cfg_addr  = 6'($urandom_range(0, N - 1));
      cfg_wdata = 13'($urandom);
      pulse_start(t);
      cfg_we = 1'b0;
      finish_xfer(t);
      check_latched_vs_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/gpio_serial_loader.md
# gpio_serial_loader

Management-side transmitter for the GPIO configuration shift chain. It holds one PAD_CTRL_BITS configuration word per GPIO and, on request, serially shifts all words into the daisy-chained GPIO control blocks around the padframe. After the last bit it pulses the load strobe so every block latches its word in the same cycle. It sits in the housekeeping domain and drives the head of the chain.

## Interface
- NUM_GPIO, 38, number of control blocks in the chain
- PAD_CTRL_BITS, 13, bits per block (must match the control blocks)
- CFG_RESET, 13'h0403, reset value of every stored configuration word
- serial_clock  in  1  block clock, free-running; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- cfg_we  in  1  write strobe for the configuration array
- cfg_addr  in  $clog2(NUM_GPIO)  GPIO index for write and readback
- cfg_wdata  in  PAD_CTRL_BITS  configuration word to write
- cfg_rdata  out  PAD_CTRL_BITS  combinational readback of word at cfg_addr
- start  in  1  single-cycle request to transfer all words into the chain
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the load strobe completes
- chain_clock  out  1  serial clock driven into the chain
- chain_data  out  1  serial data into the first block
- chain_load  out  1  load strobe into the chain
- chain_resetn  out  1  equal to resetn, passed straight through

## Operation
- Storage: NUM_GPIO x PAD_CTRL_BITS array, all entries = CFG_RESET on reset. Write when cfg_we=1, busy=0, cfg_addr<NUM_GPIO; otherwise ignored (writes while busy are dropped, not queued). cfg_rdata = 0 for out-of-range address.
- Chain order: index 0 is the block nearest the loader, NUM_GPIO-1 the farthest. Each block is a PAD_CTRL_BITS-stage shift register, MSB exits first, so transmission order is word NUM_GPIO-1 bit PAD_CTRL_BITS-1 first, down to word 0 bit 0 last. Total NUM_GPIO*PAD_CTRL_BITS rising edges of chain_clock.
- The word array is snapshotted neither before nor during transfer; writes are blocked while busy, so the array is stable.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD, FINISH.
  - IDLE: start=1 -> SHIFT_LO with gpio counter = NUM_GPIO-1, bit counter = PAD_CTRL_BITS-1.
  - SHIFT_LO: chain_clock=0, chain_data = word[gpio][bit] -> SHIFT_HI.
  - SHIFT_HI: chain_clock=1, chain_data held. If bit>0, decrement bit and go to SHIFT_LO; else if gpio>0, decrement gpio, bit = PAD_CTRL_BITS-1, go to SHIFT_LO; else go to LOAD_SETUP.
  - LOAD_SETUP: chain_clock=0, chain_load=0, one cycle -> LOAD.
  - LOAD: chain_load=1 for exactly 2 cycles -> FINISH.
  - FINISH: chain_load=0, done=1, busy=0 -> IDLE.
- start while busy is ignored; start in the same cycle as a cfg_we: the write is performed and the transfer begins next cycle with the new value.
- chain_clock never toggles outside SHIFT_LO/SHIFT_HI; chain_data = 0 outside shifting.

## Timing
- All outputs except cfg_rdata and chain_resetn are registered.
- Reset values: busy=0, done=0, chain_clock=0, chain_data=0, chain_load=0, state IDLE, counters 0.
- start accepted at edge t: busy=1, SHIFT_LO outputs at t+1; first chain_clock rise at t+2; bit k (0-based) rises at t+2+2k.
- chain_data changes only while chain_clock is low (one full serial_clock period of setup and hold around each chain_clock rise).
- Last rise at t+2*N*W (N=NUM_GPIO, W=PAD_CTRL_BITS); chain_load high at t+2NW+2 and t+2NW+3; done=1, busy=0 at t+2NW+4. Default parameters: 992 cycles start-to-done.
- Reset asserted mid-transfer: all outputs to reset values immediately (asynchronous), array returns to CFG_RESET, no load strobe issued; chain_resetn simultaneously clears the blocks.

## Test plan
- Reset: release resetn -> all outputs 0, cfg_rdata at every address = 13'h0403, busy=0.
- Write/readback: write 13'h1ABC to addr 5, 13'h0001 to addr 37, 13'h0000 to addr 40 -> readback 13'h1ABC, 13'h0001, out-of-range read 0, no other entry changed.
- Full transfer with behavioural model of NUM_GPIO=38 chained control blocks: random words, pulse start -> exactly 494 chain_clock rises, one 2-cycle chain_load, done at cycle 992; each model block latches its own word.
- Protocol check: monitor asserts chain_data stable whenever chain_clock=1 and chain_load never high while chain_clock=1 or during shifting.
- Busy rules: start and cfg_we to addr 0 issued at cycle 100 of a transfer -> no restart, addr 0 unchanged, done only once at cycle 992.
- Mid-transfer reset: assert resetn low at cycle 300 -> chain_clock/chain_load/busy 0 in same cycle, no done pulse; a new start after release completes normally with CFG_RESET words.
